// File: rtl/cla_pipe_adder_if.sv
// Operand/result stream bundle for the pipelined lookahead adder.
// Slave side is the adder; master side feeds operands and drains results.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             gen;
  logic             prop;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, gen, prop
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, gen, prop
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, GROUP-bit lookahead groups.
// Each stage resolves one WIDTH/STAGES slice; carry and G/P are registered.
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cla_pipe_adder_if.slave  bus
);
  localparam int NGRP = WIDTH / GROUP;
  localparam int SW   = WIDTH / STAGES;
  localparam int GPS  = NGRP / STAGES;
  localparam int L    = STAGES - 1;

  logic             vld_d [STAGES];
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_d   [STAGES];
  logic             c_q   [STAGES];
  logic             g_d   [STAGES];
  logic             g_q   [STAGES];
  logic             p_d   [STAGES];
  logic             p_q   [STAGES];
  logic             ovf_d [STAGES];
  logic             ovf_q [STAGES];

  logic advance;

  assign advance       = bus.out_ready | ~vld_q[L];
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[L];
  assign bus.s         = s_q[L];
  assign bus.cout      = c_q[L];
  assign bus.ovf       = ovf_q[L];
  assign bus.gen       = g_q[L];
  assign bus.prop      = p_q[L];

  // Per stage: resolve one slice group-by-group from the incoming carry.
  always_comb begin
    logic [WIDTH-1:0] ai, bi, si;
    logic va, ci, gi, pi;
    logic c, cb, cm, gs, ps;
    logic grp_g, grp_p, pb, gb;
    int   kp, idx;
    for (int k = 0; k < STAGES; k++) begin
      kp = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        va = bus.in_valid;
        ai = bus.a;
        bi = bus.b ^ {WIDTH{bus.sub}};
        ci = bus.cin ^ bus.sub;
        si = '0;
        gi = 1'b0;
        pi = 1'b1;
      end else begin
        va = vld_q[kp];
        ai = a_q[kp];
        bi = b_q[kp];
        ci = c_q[kp];
        si = s_q[kp];
        gi = g_q[kp];
        pi = p_q[kp];
      end
      c  = ci;
      cm = 1'b0;
      gs = 1'b0;
      ps = 1'b1;
      for (int gg = 0; gg < GPS; gg++) begin
        grp_g = 1'b0;
        grp_p = 1'b1;
        cb    = c;
        for (int j = 0; j < GROUP; j++) begin
          idx = k * SW + gg * GROUP + j;
          pb  = ai[idx] ^ bi[idx];
          gb  = ai[idx] & bi[idx];
          if (idx == WIDTH - 1) cm = cb;
          si[idx] = pb ^ cb;
          cb      = gb | (pb & cb);
          grp_g   = gb | (pb & grp_g);
          grp_p   = grp_p & pb;
        end
        c  = grp_g | (grp_p & c);
        gs = grp_g | (grp_p & gs);
        ps = ps & grp_p;
      end
      vld_d[k] = va;
      a_d[k]   = ai;
      b_d[k]   = bi;
      s_d[k]   = si;
      c_d[k]   = c;
      g_d[k]   = gs | (ps & gi);
      p_d[k]   = ps & pi;
      ovf_d[k] = cm ^ c;
    end
  end

  // Stage registers: reset wins, otherwise shift only when not stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        g_q[k]   <= 1'b0;
        p_q[k]   <= 1'b0;
        ovf_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
        g_q[k]   <= g_d[k];
        p_q[k]   <= p_d[k];
        ovf_q[k] <= ovf_d[k];
      end
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: STAGES 1/2/4 side by side, shared stimulus.
// Results packed as {ovf,gen,prop,cout,s}.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;

  int checks   = 0;
  int failures = 0;

  cla_pipe_adder_if #(.WIDTH(16)) if1 ();
  cla_pipe_adder_if #(.WIDTH(16)) if2 ();
  cla_pipe_adder_if #(.WIDTH(16)) if4 ();

  assign if1.in_valid  = in_valid;
  assign if1.a         = a;
  assign if1.b         = b;
  assign if1.cin       = cin;
  assign if1.sub       = sub;
  assign if1.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.a         = a;
  assign if2.b         = b;
  assign if2.cin       = cin;
  assign if2.sub       = sub;
  assign if2.out_ready = out_ready;
  assign if4.in_valid  = in_valid;
  assign if4.a         = a;
  assign if4.b         = b;
  assign if4.cin       = cin;
  assign if4.sub       = sub;
  assign if4.out_ready = out_ready;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );
  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave)
  );
  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [19:0] ex;
  } vec_t;

  vec_t tbl [7] = '{
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, {4'b0000, 16'h0100}},
    '{16'hFFFF, 16'h0000, 1'b1, 1'b0, {4'b0011, 16'h0000}},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, {4'b1101, 16'h7FFF}},
    '{16'h0003, 16'h0005, 1'b0, 1'b1, {4'b0000, 16'hFFFE}},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {4'b1000, 16'h8000}},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {4'b0101, 16'hFFFF}},
    '{16'h1234, 16'h1234, 1'b0, 1'b1, {4'b0011, 16'h0000}}
  };

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] mdl(input logic [15:0] x, y,
                                      input logic ci, sb);
    logic [15:0] be;
    logic        ce;
    logic [16:0] sum;
    logic [16:0] gsum;
    logic [15:0] low;
    be   = y ^ {16{sb}};
    ce   = ci ^ sb;
    sum  = {1'b0, x} + {1'b0, be} + {16'b0, ce};
    gsum = {1'b0, x} + {1'b0, be};
    low  = {1'b0, x[14:0]} + {1'b0, be[14:0]} + {15'b0, ce};
    return {low[15] ^ sum[16], gsum[16], &(x ^ be), sum[16], sum[15:0]};
  endfunction

  function automatic logic [19:0] obs(input int k);
    case (k)
      1:       return {if1.ovf, if1.gen, if1.prop, if1.cout, if1.s};
      2:       return {if2.ovf, if2.gen, if2.prop, if2.cout, if2.s};
      default: return {if4.ovf, if4.gen, if4.prop, if4.cout, if4.s};
    endcase
  endfunction

  function automatic logic ovld(input int k);
    case (k)
      1:       return if1.out_valid;
      2:       return if2.out_valid;
      default: return if4.out_valid;
    endcase
  endfunction

  task automatic run_vec(input string tag, input logic [15:0] va, vb,
                         input logic vc, vs, input logic [19:0] ex);
    logic [19:0] r;
    a = va; b = vb; cin = vc; sub = vs;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int k;
        k = 1 << i;
        chk($sformatf("%s_lat_s%0d_c%0d", tag, k, n),
            {31'b0, ovld(k)}, {31'b0, n == k});
        if (n == k) begin
          r = obs(k);
          chk($sformatf("%s_res_s%0d", tag, k), {12'b0, r}, {12'b0, ex});
          chk($sformatf("%s_inv_s%0d", tag, k), {31'b0, r[16]},
              {31'b0, r[18] | (r[17] & (vc ^ vs))});
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_q [$];
    logic [19:0] held;
    logic [19:0] mv;
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic        held_v;
    int          sent, got;

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_vld_s%0d", 1 << i), {31'b0, ovld(1 << i)}, 0);
      chk($sformatf("rst_out_s%0d", 1 << i), {12'b0, obs(1 << i)}, 0);
    end
    chk("rst_rdy", {31'b0, if2.in_ready}, 1);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk($sformatf("idle_vld_%0d", n), {31'b0, if2.out_valid}, 0);
    end

    foreach (tbl[i])
      run_vec($sformatf("dir%0d", i), tbl[i].a, tbl[i].b,
              tbl[i].cin, tbl[i].sub, tbl[i].ex);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_vec($sformatf("rnd%0d", i), ra, rb, rc, rs, mdl(ra, rb, rc, rs));
    end

    sent = 0; got = 0; held_v = 1'b0; held = '0;
    cin = 1'b0; sub = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      if (sent < 4) begin
        a = 16'h1000 * 16'(sent + 1) + 16'(sent);
        b = 16'h0101;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(t >= 3 && t <= 5);
      @(negedge clk);
      if (if2.out_valid && out_ready) begin
        got++;
        if (exp_q.size() > 0) chk("bp_res", {16'b0, if2.s},
                                  {16'b0, exp_q.pop_front()});
      end
      if (if2.out_valid && !out_ready) begin
        chk("bp_rdy", {31'b0, if2.in_ready}, 0);
        if (held_v) chk("bp_hold", {12'b0, obs(2)}, {12'b0, held});
        held = obs(2);
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (in_valid && if2.in_ready) begin
        mv = mdl(a, b, 1'b0, 1'b0);
        exp_q.push_back(mv[15:0]);
        sent++;
      end
    end
    chk("bp_got", got, 4);
    chk("bp_sent", sent, 4);

    out_ready = 1'b1;
    do_reset();
    @(posedge clk);
    #1 a = 16'h0011; b = 16'h0022; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("mid_vld0", {31'b0, if2.out_valid}, 0);
    @(posedge clk);
    #1 a = 16'h0033; b = 16'h0044;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_vld1", {31'b0, if2.out_valid}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk($sformatf("mid_drop_%0d", n), {31'b0, if2.out_valid}, 0);
    end
    run_vec("post_rst", 16'h4321, 16'h1111, 1'b1, 1'b0,
            {4'b0000, 16'h5433});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
